jogador_automatico_exp5: RTL and testbench



---
 rtl/jogador_automatico_exp5.sv | 206 ++++++++++++++++++++
 tb/tb_jogador_automatico_exp5.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico_exp5.sv
// jogador_automatico_exp5
//   Automatic player for the Experiencia 5 memory game. It pulses iniciar,
//   plays a fixed table of one-hot jogadas on chaves and can make jogada
//   ERRO_EM deliberately wrong. It then latches the game's verdict and flags
//   inconsistente when that verdict is not the one this configuration expects.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   ativar              level, starts one game from OCIOSO
//   pronto/acertou/errou game result inputs (used only in VERIFICA/AGUARDA)
//   iniciar, chaves     drive the game's player inputs
//   ocupado, fim        status (busy / finished)
//   viu_acerto/viu_erro latched verdict
//   inconsistente       verdict differs from expectation, or pronto timed out
//   jogadas_feitas      jogadas completed in this game
//   db_estado           state code, debug
module jogador_automatico_exp5 #(
  parameter int N_JOGADAS   = 16,
  parameter int T_INICIAR   = 5,
  parameter int T_JOGADA    = 10,
  parameter int T_INTERVALO = 10,
  parameter int T_TIMEOUT   = 200,
  parameter int ERRO_EM     = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ativar,
  input  logic       pronto,
  input  logic       acertou,
  input  logic       errou,
  output logic       iniciar,
  output logic [3:0] chaves,
  output logic       ocupado,
  output logic       fim,
  output logic       viu_acerto,
  output logic       viu_erro,
  output logic       inconsistente,
  output logic [4:0] jogadas_feitas,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    INICIA     = 3'd1,
    ESPERA_INI = 3'd2,
    APERTA     = 3'd3,
    SOLTA      = 3'd4,
    VERIFICA   = 3'd5,
    AGUARDA    = 3'd6,
    FIM        = 3'd7
  } estado_t;

  // An out-of-range error position means "no wrong jogada".
  localparam int ERRO_EF = (ERRO_EM < 1 || ERRO_EM > N_JOGADAS) ? 0 : ERRO_EM;

  localparam logic [4:0] N_J    = 5'(N_JOGADAS);
  localparam logic [4:0] JF_ESP = (ERRO_EF == 0) ? 5'(N_JOGADAS) : 5'(ERRO_EF);
  localparam logic [4:0] ERRO_J = 5'(ERRO_EF);

  // Timer runs 0..T-1 inside a state; the last count is the exit cycle.
  localparam logic [7:0] LIM_INI = 8'(T_INICIAR - 1);
  localparam logic [7:0] LIM_JOG = 8'(T_JOGADA - 1);
  localparam logic [7:0] LIM_INT = 8'(T_INTERVALO - 1);
  localparam logic [7:0] LIM_TO  = 8'(T_TIMEOUT - 1);

  estado_t    estado, prox;
  logic [7:0] timer, lim;
  logic [4:0] index;
  logic       expira, veredito_ok;

  logic       nx_iniciar, nx_ocupado, nx_fim;
  logic       nx_va, nx_ve, nx_inc;
  logic [3:0] nx_chaves;
  logic [4:0] nx_jf, nx_idx;

  // Correct jogada for table position idx, rotated left when it is the
  // jogada chosen to be wrong (jogadas are numbered from 1).
  function automatic logic [3:0] jogada(input logic [4:0] idx);
    logic [3:0] j;
    case (idx[3:0])
      4'd0:  j = 4'b0001;
      4'd1:  j = 4'b0010;
      4'd2:  j = 4'b0100;
      4'd3:  j = 4'b1000;
      4'd4:  j = 4'b0100;
      4'd5:  j = 4'b0010;
      4'd6:  j = 4'b0001;
      4'd7:  j = 4'b0001;
      4'd8:  j = 4'b0010;
      4'd9:  j = 4'b0010;
      4'd10: j = 4'b0100;
      4'd11: j = 4'b0100;
      4'd12: j = 4'b1000;
      4'd13: j = 4'b1000;
      4'd14: j = 4'b0001;
      default: j = 4'b0100;
    endcase
    if (ERRO_EF != 0 && (idx + 5'd1) == ERRO_J) j = {j[2:0], j[3]};
    return j;
  endfunction

  always_comb begin
    lim = 8'd0;
    case (estado)
      INICIA:             lim = LIM_INI;
      ESPERA_INI, SOLTA:  lim = LIM_INT;
      APERTA:             lim = LIM_JOG;
      AGUARDA:            lim = LIM_TO;
      default:            lim = 8'd0;
    endcase
  end

  assign expira = (timer == lim);

  // The game's verdict is evaluated with jogadas_feitas already updated by
  // the last APERTA exit.
  always_comb begin
    if (ERRO_EF == 0) veredito_ok = acertou && !errou && (jogadas_feitas == JF_ESP);
    else              veredito_ok = errou && !acertou && (jogadas_feitas == JF_ESP);
  end

  // State register, timer and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= OCIOSO;
      timer          <= 8'd0;
      index          <= 5'd0;
      iniciar        <= 1'b0;
      chaves         <= 4'b0000;
      ocupado        <= 1'b0;
      fim            <= 1'b0;
      viu_acerto     <= 1'b0;
      viu_erro       <= 1'b0;
      inconsistente  <= 1'b0;
      jogadas_feitas <= 5'd0;
      db_estado      <= 4'd0;
    end else begin
      estado         <= prox;
      timer          <= (prox != estado) ? 8'd0 : timer + 8'd1;
      index          <= nx_idx;
      iniciar        <= nx_iniciar;
      chaves         <= nx_chaves;
      ocupado        <= nx_ocupado;
      fim            <= nx_fim;
      viu_acerto     <= nx_va;
      viu_erro       <= nx_ve;
      inconsistente  <= nx_inc;
      jogadas_feitas <= nx_jf;
      db_estado      <= {1'b0, prox};
    end
  end

  // Next state.
  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:     if (ativar) prox = INICIA;
      INICIA:     if (expira) prox = ESPERA_INI;
      ESPERA_INI: if (expira) prox = APERTA;
      APERTA:     if (expira) prox = SOLTA;
      SOLTA:      if (expira) prox = VERIFICA;
      VERIFICA: begin
        if (pronto)                      prox = FIM;
        else if (jogadas_feitas == N_J)  prox = AGUARDA;
        else                             prox = APERTA;
      end
      AGUARDA:    if (pronto || expira) prox = FIM;
      FIM:        if (!ativar) prox = OCIOSO;
      default:    prox = OCIOSO;
    endcase
  end

  // Next values of the registered outputs, derived from the state being
  // entered so each output lines up with db_estado.
  always_comb begin
    nx_jf  = jogadas_feitas;
    nx_idx = index;
    nx_va  = viu_acerto;
    nx_ve  = viu_erro;
    nx_inc = inconsistente;

    if (estado == OCIOSO && prox == INICIA) begin
      nx_jf  = 5'd0;
      nx_idx = 5'd0;
      nx_va  = 1'b0;
      nx_ve  = 1'b0;
      nx_inc = 1'b0;
    end
    if (estado == APERTA && expira) nx_jf = jogadas_feitas + 5'd1;
    if (estado == VERIFICA && !pronto && jogadas_feitas != N_J) nx_idx = index + 5'd1;

    if ((estado == VERIFICA || estado == AGUARDA) && pronto) begin
      nx_va  = acertou;
      nx_ve  = errou;
      nx_inc = !veredito_ok;
    end else if (estado == AGUARDA && expira) begin
      nx_inc = 1'b1;
    end

    nx_iniciar = (prox == INICIA);
    nx_chaves  = (prox == APERTA) ? jogada(nx_idx) : 4'b0000;
    nx_ocupado = (prox != OCIOSO) && (prox != FIM);
    nx_fim     = (prox == FIM);
  end

endmodule

// File: tb/tb_jogador_automatico_exp5.sv
// Bench for jogador_automatico_exp5. Two instances (ERRO_EM=0 and ERRO_EM=5)
// share the same stimulus; each is compared every cycle against a timeline
// computed from the game schedule, and table scenarios also check the final
// verdict against hand-derived values.
module tb_jogador_automatico_exp5;

  logic clk = 1'b0;
  logic reset, ativar, pronto, acertou, errou;

  logic       iniciar_o [2];
  logic [3:0] chaves_o  [2];
  logic       ocupado_o [2];
  logic       fim_o     [2];
  logic       va_o      [2];
  logic       ve_o      [2];
  logic       inc_o     [2];
  logic [4:0] jf_o      [2];
  logic [3:0] db_o      [2];

  int checks = 0;
  int errors = 0;

  int erro_of [2] = '{0, 5};
  logic [3:0] jtab [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                            4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                            4'b1000, 4'b1000, 4'b0001, 4'b0100};

  always #5 clk = ~clk;

  jogador_automatico_exp5 #(.ERRO_EM(0)) dut0 (
    .clock(clk), .reset(reset), .ativar(ativar), .pronto(pronto),
    .acertou(acertou), .errou(errou), .iniciar(iniciar_o[0]), .chaves(chaves_o[0]),
    .ocupado(ocupado_o[0]), .fim(fim_o[0]), .viu_acerto(va_o[0]), .viu_erro(ve_o[0]),
    .inconsistente(inc_o[0]), .jogadas_feitas(jf_o[0]), .db_estado(db_o[0]));

  jogador_automatico_exp5 #(.ERRO_EM(5)) dut5 (
    .clock(clk), .reset(reset), .ativar(ativar), .pronto(pronto),
    .acertou(acertou), .errou(errou), .iniciar(iniciar_o[1]), .chaves(chaves_o[1]),
    .ocupado(ocupado_o[1]), .fim(fim_o[1]), .viu_acerto(va_o[1]), .viu_erro(ve_o[1]),
    .inconsistente(inc_o[1]), .jogadas_feitas(jf_o[1]), .db_estado(db_o[1]));

  // k: 1..16 = pronto arrives for jogada k; 17 = pronto d cycles into
  // AGUARDA; 0 = pronto never comes (timeout).
  typedef struct {
    int k;
    bit ac;
    bit er;
    int d;
    int hold;
    int jf;
    bit va;
    bit ve;
    bit inc0;
    bit inc5;
  } vec_t;

  function automatic logic [18:0] obs(int i);
    return {iniciar_o[i], chaves_o[i], ocupado_o[i], fim_o[i], va_o[i], ve_o[i],
            inc_o[i], jf_o[i], db_o[i]};
  endfunction

  function automatic logic [3:0] jog(int j, int e);
    logic [3:0] t;
    t = jtab[j];
    if (j + 1 == e) t = {t[2:0], t[3]};
    return t;
  endfunction

  function automatic bit verdict_ok(int e, bit ac, bit er, int jf);
    if (e == 0) return ac && !er && jf == 16;
    return er && !ac && jf == e;
  endfunction

  task automatic chk(string nm, int i, logic [18:0] got, logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, i, $time, got, exp);
    end
  endtask

  task automatic run_game(input vec_t v, input bit use_tab, input int abort_at);
    int cf, p, fjf, m, j, r, db;
    bit tout, fva, fve, verif;
    bit finc [2];
    logic [3:0] ch;
    bit ini, oc, fm, va, ve, inc;
    int jf;
    if (v.k >= 1 && v.k <= 16) begin
      cf  = 36 + 21 * (v.k - 1);
      p   = int'($urandom_range(35 + 21 * (v.k - 1), 25 + 21 * (v.k - 1)));
      fjf = v.k;
    end else if (v.k == 17) begin
      p = 351 + v.d; cf = p + 1; fjf = 16;
    end else begin
      p = 1 << 30; cf = 551; fjf = 16;
    end
    tout = (v.k == 0);
    fva  = tout ? 1'b0 : v.ac;
    fve  = tout ? 1'b0 : v.er;
    for (int i = 0; i < 2; i++) finc[i] = tout ? 1'b1 : !verdict_ok(erro_of[i], v.ac, v.er, fjf);

    ativar = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= cf + v.hold + 1; c++) begin
      for (int i = 0; i < 2; i++) begin
        ini = 0; ch = 4'b0; oc = 0; fm = 0; va = 0; ve = 0; inc = 0; jf = 0; db = 0;
        if (c < cf) begin
          oc = 1;
          if (c < 5) begin db = 1; ini = 1; end
          else if (c < 15) db = 2;
          else if (c < 351) begin
            m = c - 15; j = m / 21; r = m % 21;
            if (r < 10) begin db = 3; ch = jog(j, erro_of[i]); jf = j; end
            else if (r < 20) begin db = 4; jf = j + 1; end
            else begin db = 5; jf = j + 1; end
          end else begin db = 6; jf = 16; end
        end else begin
          db = (c <= cf + v.hold) ? 7 : 0;
          fm = (c <= cf + v.hold);
          jf = fjf; va = fva; ve = fve; inc = finc[i];
        end
        chk("cycle", i, obs(i), {ini, ch, oc, fm, va, ve, inc, 5'(jf), 4'(db)});
      end
      if (use_tab && c == cf) begin
        chk("verdict", 0, 19'({jf_o[0], va_o[0], ve_o[0], inc_o[0]}),
            19'({5'(v.jf), v.va, v.ve, v.inc0}));
        chk("verdict", 1, 19'({jf_o[1], va_o[1], ve_o[1], inc_o[1]}),
            19'({5'(v.jf), v.va, v.ve, v.inc5}));
      end
      if (c == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) chk("reset_mid", i, obs(i), 19'd0);
        reset = 1'b0;
        ativar = 1'b0;
        return;
      end
      // Inputs for this cycle; pronto noise only where the player ignores it.
      ativar = (c < cf) ? 1'($urandom_range(1, 0)) : (c < cf + v.hold);
      if (c >= p) begin
        pronto = 1'b1; acertou = v.ac; errou = v.er;
      end else begin
        verif   = (c >= 15 && c < 351 && (c - 15) % 21 == 20);
        pronto  = (verif || c >= 351) ? 1'b0 : 1'($urandom_range(1, 0));
        acertou = 1'($urandom_range(1, 0));
        errou   = 1'($urandom_range(1, 0));
      end
      if (c < cf + v.hold + 1) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    vec_t tab [7];
    vec_t rv;
    //          k   ac er d    hold jf  va ve inc0 inc5
    tab[0] = '{16, 1, 0, 0,   3,   16, 1, 0, 0, 1};
    tab[1] = '{5,  0, 1, 0,   0,   5,  0, 1, 1, 0};
    tab[2] = '{5,  1, 0, 0,   1,   5,  1, 0, 1, 1};
    tab[3] = '{0,  0, 0, 0,   2,   16, 0, 0, 1, 1};
    tab[4] = '{17, 1, 1, 0,   0,   16, 1, 1, 1, 1};
    tab[5] = '{17, 1, 0, 199, 1,   16, 1, 0, 0, 1};
    tab[6] = '{1,  0, 1, 0,   2,   1,  0, 1, 1, 1};

    reset = 1'b1; ativar = 1'b0; pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) chk("reset", i, obs(i), 19'd0);
    reset = 1'b0;

    for (int t = 0; t < 7; t++) run_game(tab[t], 1'b1, -1);

    // Reset while jogada 3 is on chaves, then a fresh game from jogada 1.
    run_game(tab[0], 1'b0, 60);
    run_game(tab[1], 1'b1, -1);

    for (int n = 0; n < 8; n++) begin
      rv.k    = int'($urandom_range(17, 0));
      rv.ac   = 1'($urandom_range(1, 0));
      rv.er   = 1'($urandom_range(1, 0));
      rv.d    = int'($urandom_range(199, 0));
      rv.hold = int'($urandom_range(3, 0));
      rv.jf = 0; rv.va = 0; rv.ve = 0; rv.inc0 = 0; rv.inc5 = 0;
      run_game(rv, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
